rdmx_recv_be: RTL and testbench
===============================

RDMX_RECV_BE -- requirements
Module: rdmx_recv_be

Interface
REQ-001 SHALL have parameter DW, default 512, data-bus width in bits.
REQ-002 SHALL have parameter AW, default 64, AXI address width in bits.
REQ-003 SHALL have parameter UW, default 32, user-data width in bits.
REQ-004 SHALL have parameter MAX_OUT, default 16, maximum outstanding AXI write bursts (1..255).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port resetn, input, 1, reset (synchronous, active-low).
REQ-007 SHALL have port AXIS_PLEN_TDATA/TVALID/TREADY, in/in/out, 16/1/1, packet length in bytes.
REQ-008 SHALL have port AXIS_ADDR_TDATA/TUSER/TVALID/TREADY, in/in/in/out, AW/UW/1/1, target address and user data.
REQ-009 SHALL have port AXIS_DATA_TDATA/TLAST/TVALID/TREADY, in/in/in/out, DW/1/1/1, packet payload.
REQ-010 SHALL have port M_AXI_AWADDR/AWUSER/AWLEN/AWSIZE/AWBURST/AWID/AWVALID, out, AW/UW/8/3/2/4/1, write-address channel; AWREADY in, 1.
REQ-011 SHALL have port M_AXI_WDATA/WSTRB/WLAST/WVALID, out, DW/DW/8/1/1, write-data channel; WREADY in, 1.
REQ-012 SHALL have port M_AXI_BRESP/BVALID, in, 2/1, write response; BREADY out, 1.
REQ-013 SHALL have port err_plen/err_tlast/err_bresp, out, 1 each, sticky error flags.
REQ-014 SHALL have port packets_written, out, 32, count of OKAY B responses.

Function
REQ-015 SHALL use states IDLE, AWDATA and DRAIN.
REQ-016 IDLE: SHALL accept PLEN and ADDR in the same cycle, and only when both are valid and outstanding < MAX_OUT; they SHALL then be latched.
REQ-017 SHALL compute beats = ceil(plen/(DW/8)), AWLEN = beats-1, AWSIZE = log2(DW/8), AWBURST = 1 (INCR), AWID = 0.
REQ-018 plen==0: SHALL issue no AXI write, set err_plen and remain in IDLE.
REQ-019 beats>256: SHALL issue no AXI write, set err_plen and enter DRAIN.
REQ-020 Otherwise SHALL enter AWDATA; AWVALID SHALL assert the cycle after acceptance and hold until AWREADY.
REQ-021 AWDATA: the W channel SHALL run concurrently with AW: WVALID = AXIS_DATA_TVALID, AXIS_DATA_TREADY = WREADY, and WDATA SHALL pass through combinationally.
REQ-022 A beat counter SHALL drive WLAST on beat index AWLEN.
REQ-023 WSTRB SHALL be all ones except on the last beat, where its low (plen mod DW/8) bits are set, or all ones if that value is 0.
REQ-024 Any accepted beat with TLAST != WLAST SHALL set err_tlast; the counter alone SHALL still define the burst.
REQ-025 Exit from AWDATA to IDLE SHALL occur only when both the AW handshake and the last W handshake have completed, in either order.
REQ-026 DRAIN: AXIS_DATA_TREADY SHALL be 1, beats SHALL be discarded, and the state SHALL return to IDLE on an accepted TLAST.
REQ-027 The outstanding counter SHALL increment on the AW handshake and decrement on the B handshake; simultaneous events SHALL leave it unchanged.
REQ-028 BREADY SHALL be 1 whenever out of reset.
REQ-029 On each B handshake, BRESP != 0 SHALL set err_bresp; otherwise packets_written SHALL increment, wrapping at 2^32.
REQ-030 Zero-latency backpressure: W ready/valid SHALL have no pipeline register; a new packet SHALL be accepted no earlier than one cycle after AWDATA exits.

Reset
REQ-031 While resetn==0, all outputs SHALL be 0: AWVALID, WVALID, BREADY, all TREADYs, error flags and counters; the state SHALL be IDLE.
REQ-032 Reset mid-burst SHALL abandon the packet immediately without completing the AXI burst; recovery of the downstream slave is out of scope.

Structure
REQ-033 Package rdmx_pkg SHALL hold the state enum, AXI BURST/RESP encodings and bytes-per-beat/AWSIZE derivation.
REQ-034 Sub-module rdmx_wstrb_gen SHALL produce the last-beat strobe from (plen mod DW/8).

Verification (DW=512)
REQ-035 plen=64, addr=0x1000, user=0xA5 -> AWLEN=0, WSTRB all ones, WLAST on beat 1, B OKAY -> packets_written=1.
REQ-036 plen=130 -> AWLEN=2, beats 1-2 WSTRB all ones, beat 3 WSTRB=0x3 with WLAST.
REQ-037 plen=0, then plen=64 -> no AW for the first packet, err_plen=1, second packet written normally.
REQ-038 MAX_OUT=2, slave withholds BVALID, 3 queued packets -> exactly 2 AWs; third AW only after the first B.
REQ-039 BRESP=2 on a packet -> err_bresp=1 and packets_written unchanged; TLAST on beat 2 of a 3-beat packet -> err_tlast=1, WLAST still on beat 3.
REQ-040 resetn low for 1 cycle during beat 2 of 4 -> all outputs 0, state IDLE, next packet written correctly.

Source files
------------

// File: rtl/rdmx_pkg.sv
// Shared types and derivations for the RDMX receive back end.
package rdmx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AWDATA = 2'd1,
    DRAIN  = 2'd2
  } rdmx_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Longest burst an AXI4 INCR transfer can describe
  localparam int unsigned MAX_BEATS = 256;

  function automatic int unsigned bytes_per_beat(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned awsize_of(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/rdmx_wstrb_gen.sv
// Last-beat byte strobe: low 'plen_rem' bytes enabled, or all bytes when the
// packet length is a whole number of beats (remainder zero).
module rdmx_wstrb_gen
  import rdmx_pkg::*;
#(
  parameter  int unsigned DW  = 512,
  localparam int unsigned BPB = bytes_per_beat(DW),
  localparam int unsigned RW  = (awsize_of(DW) == 0) ? 1 : awsize_of(DW)
) (
  input  logic [RW-1:0]  plen_rem,
  output logic [BPB-1:0] last_strb
);

  logic rem_zero;
  assign rem_zero = (plen_rem == '0);

  for (genvar gi = 0; gi < BPB; gi++) begin : g_strb
    assign last_strb[gi] = rem_zero || (RW'(gi) < plen_rem);
  end

endmodule

// File: rtl/rdmx_recv_be.sv
// Receive back end: turns (length, address, payload) AXI-Stream packets into
// single AXI4 INCR write bursts, with outstanding-burst limiting and sticky
// error reporting.
module rdmx_recv_be
  import rdmx_pkg::*;
#(
  parameter int unsigned DW      = 512,
  parameter int unsigned AW      = 64,
  parameter int unsigned UW      = 32,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [15:0]     AXIS_PLEN_TDATA,
  input  logic            AXIS_PLEN_TVALID,
  output logic            AXIS_PLEN_TREADY,
  input  logic [AW-1:0]   AXIS_ADDR_TDATA,
  input  logic [UW-1:0]   AXIS_ADDR_TUSER,
  input  logic            AXIS_ADDR_TVALID,
  output logic            AXIS_ADDR_TREADY,
  input  logic [DW-1:0]   AXIS_DATA_TDATA,
  input  logic            AXIS_DATA_TLAST,
  input  logic            AXIS_DATA_TVALID,
  output logic            AXIS_DATA_TREADY,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [UW-1:0]   M_AXI_AWUSER,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic [3:0]      M_AXI_AWID,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic            err_plen,
  output logic            err_tlast,
  output logic            err_bresp,
  output logic [31:0]     packets_written
);

  localparam int unsigned BPB = bytes_per_beat(DW);
  localparam int unsigned SZ  = awsize_of(DW);
  localparam int unsigned RW  = (SZ == 0) ? 1 : SZ;
  localparam logic [7:0]  OUT_LIMIT = 8'(MAX_OUT);

  rdmx_state_e       state_reg, state_next;
  logic [AW-1:0]     awaddr_reg;
  logic [UW-1:0]     awuser_reg;
  logic [7:0]        awlen_reg;
  logic              awvalid_reg;
  logic [RW-1:0]     plen_rem_reg;
  logic [7:0]        beat_cnt_reg;
  logic              w_done_reg;
  logic [7:0]        out_cnt_reg;
  logic              err_plen_reg, err_tlast_reg, err_bresp_reg;
  logic [31:0]       pkt_cnt_reg;

  logic [16:0]       beats_calc;
  logic              plen_zero, too_long, accept;
  logic              w_active, wlast, aw_hs, w_hs, b_hs;
  logic              aw_done_now, w_done_now;
  logic [BPB-1:0]    last_strb;

  // Beat count of the offered packet, wide enough for any 16-bit length
  assign beats_calc = (17'(AXIS_PLEN_TDATA) + 17'(BPB - 1)) >> SZ;
  assign plen_zero  = (AXIS_PLEN_TDATA == 16'd0);
  assign too_long   = (beats_calc > 17'(MAX_BEATS));

  // Length and address are taken together, and only with room for another burst
  assign accept = resetn && (state_reg == IDLE) && AXIS_PLEN_TVALID &&
                  AXIS_ADDR_TVALID && (out_cnt_reg < OUT_LIMIT);

  // W side is a straight wire to the stream while the burst still wants beats
  assign w_active = resetn && (state_reg == AWDATA) && !w_done_reg;
  assign wlast    = w_active && (beat_cnt_reg == awlen_reg);
  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs     = M_AXI_BVALID && M_AXI_BREADY;

  // The two channels may finish in either order; leave only when both have
  assign aw_done_now = !awvalid_reg || aw_hs;
  assign w_done_now  = w_done_reg || (w_hs && wlast);

  rdmx_wstrb_gen #(.DW(DW)) u_wstrb_gen (
    .plen_rem  (plen_rem_reg),
    .last_strb (last_strb)
  );

  assign AXIS_PLEN_TREADY = accept;
  assign AXIS_ADDR_TREADY = accept;
  assign AXIS_DATA_TREADY = (w_active && M_AXI_WREADY) ||
                            (resetn && (state_reg == DRAIN));

  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWUSER  = awuser_reg;
  assign M_AXI_AWLEN   = awlen_reg;
  assign M_AXI_AWSIZE  = 3'(SZ);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWID    = 4'd0;
  assign M_AXI_AWVALID = resetn && awvalid_reg;

  assign M_AXI_WDATA  = w_active ? AXIS_DATA_TDATA : '0;
  assign M_AXI_WSTRB  = !w_active ? '0 : (wlast ? last_strb : '1);
  assign M_AXI_WLAST  = wlast;
  assign M_AXI_WVALID = w_active && AXIS_DATA_TVALID;
  assign M_AXI_BREADY = resetn;

  assign err_plen        = err_plen_reg;
  assign err_tlast       = err_tlast_reg;
  assign err_bresp       = err_bresp_reg;
  assign packets_written = pkt_cnt_reg;

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept && !plen_zero) state_next = too_long ? DRAIN : AWDATA;
      AWDATA:  if (aw_done_now && w_done_now) state_next = IDLE;
      DRAIN:   if (AXIS_DATA_TVALID && AXIS_DATA_TLAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and per-burst control (latched request, beat tracking)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      awaddr_reg   <= '0;
      awuser_reg   <= '0;
      awlen_reg    <= '0;
      awvalid_reg  <= 1'b0;
      plen_rem_reg <= '0;
      beat_cnt_reg <= '0;
      w_done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        awaddr_reg   <= AXIS_ADDR_TDATA;
        awuser_reg   <= AXIS_ADDR_TUSER;
        awlen_reg    <= 8'(beats_calc - 17'd1);
        plen_rem_reg <= AXIS_PLEN_TDATA[RW-1:0];
        beat_cnt_reg <= '0;
        w_done_reg   <= 1'b0;
        awvalid_reg  <= !plen_zero && !too_long;
      end
      if (aw_hs) awvalid_reg <= 1'b0;
      if (w_hs) begin
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
        if (wlast) w_done_reg <= 1'b1;
      end
    end
  end

  // Outstanding-burst count, sticky errors and completed-packet counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_cnt_reg   <= '0;
      err_plen_reg  <= 1'b0;
      err_tlast_reg <= 1'b0;
      err_bresp_reg <= 1'b0;
      pkt_cnt_reg   <= '0;
    end else begin
      unique case ({aw_hs, b_hs})
        2'b10:   out_cnt_reg <= out_cnt_reg + 8'd1;
        2'b01:   out_cnt_reg <= out_cnt_reg - 8'd1;
        default: out_cnt_reg <= out_cnt_reg;
      endcase
      if (accept && (plen_zero || too_long)) err_plen_reg <= 1'b1;
      if (w_hs && (AXIS_DATA_TLAST != wlast)) err_tlast_reg <= 1'b1;
      if (b_hs) begin
        if (M_AXI_BRESP != AXI_RESP_OKAY) err_bresp_reg <= 1'b1;
        else pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rdmx_recv_be.sv
// Randomised self-checking bench for rdmx_recv_be (DW=512, MAX_OUT=2).
module tb_rdmx_recv_be;

  localparam int DW = 512, AW = 64, UW = 32, MAX_OUT = 2, BPB = DW / 8;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [15:0] plen_tdata = '0;
  logic plen_tvalid = 1'b0, plen_tready;
  logic [AW-1:0] addr_tdata = '0;
  logic [UW-1:0] addr_tuser = '0;
  logic addr_tvalid = 1'b0, addr_tready;
  logic [DW-1:0] data_tdata = '0;
  logic data_tlast = 1'b0, data_tvalid = 1'b0, data_tready;
  logic [AW-1:0] aw_addr;
  logic [UW-1:0] aw_user;
  logic [7:0] aw_len;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic [3:0] aw_id;
  logic aw_valid, aw_ready;
  logic [DW-1:0] w_data;
  logic [BPB-1:0] w_strb;
  logic w_last, w_valid, w_ready;
  logic [1:0] b_resp;
  logic b_valid, b_ready;
  logic err_plen, err_tlast, err_bresp;
  logic [31:0] packets_written;

  rdmx_recv_be #(.DW(DW), .AW(AW), .UW(UW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_PLEN_TDATA(plen_tdata), .AXIS_PLEN_TVALID(plen_tvalid), .AXIS_PLEN_TREADY(plen_tready),
    .AXIS_ADDR_TDATA(addr_tdata), .AXIS_ADDR_TUSER(addr_tuser),
    .AXIS_ADDR_TVALID(addr_tvalid), .AXIS_ADDR_TREADY(addr_tready),
    .AXIS_DATA_TDATA(data_tdata), .AXIS_DATA_TLAST(data_tlast),
    .AXIS_DATA_TVALID(data_tvalid), .AXIS_DATA_TREADY(data_tready),
    .M_AXI_AWADDR(aw_addr), .M_AXI_AWUSER(aw_user), .M_AXI_AWLEN(aw_len),
    .M_AXI_AWSIZE(aw_size), .M_AXI_AWBURST(aw_burst), .M_AXI_AWID(aw_id),
    .M_AXI_AWVALID(aw_valid), .M_AXI_AWREADY(aw_ready),
    .M_AXI_WDATA(w_data), .M_AXI_WSTRB(w_strb), .M_AXI_WLAST(w_last),
    .M_AXI_WVALID(w_valid), .M_AXI_WREADY(w_ready),
    .M_AXI_BRESP(b_resp), .M_AXI_BVALID(b_valid), .M_AXI_BREADY(b_ready),
    .err_plen(err_plen), .err_tlast(err_tlast), .err_bresp(err_bresp),
    .packets_written(packets_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [UW-1:0] user;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [3:0]    id;
    int            t;
  } aw_rec_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [BPB-1:0] strb;
    logic           last;
  } w_rec_t;

  aw_rec_t aw_q[$];
  w_rec_t  w_q[$];
  int      b_t[$];
  int      cyc = 0;

  logic [DW-1:0] beat_data [0:299];

  int checks = 0, passes = 0;
  bit rand_ready = 0, b_enable = 0;
  int b_issued = 0, b_seen = 0, bad_idx = -1;
  bit exp_err_plen = 0, exp_err_tlast = 0, exp_err_bresp = 0;
  int exp_pw = 0;

  // Observer: record every AXI handshake the DUT makes
  initial begin
    aw_rec_t ar;
    w_rec_t  wr;
    forever begin
      @(posedge clk);
      cyc++;
      if (resetn) begin
        if (aw_valid && aw_ready) begin
          ar.addr = aw_addr; ar.user = aw_user; ar.len = aw_len;
          ar.size = aw_size; ar.burst = aw_burst; ar.id = aw_id; ar.t = cyc;
          aw_q.push_back(ar);
        end
        if (w_valid && w_ready) begin
          wr.data = w_data; wr.strb = w_strb; wr.last = w_last;
          w_q.push_back(wr);
        end
        if (b_valid && b_ready) b_t.push_back(cyc);
      end
    end
  end

  // AXI slave: optional random ready, one B per accepted AW when enabled
  initial begin
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    forever begin
      @(negedge clk);
      aw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_valid && b_t.size() != b_seen) begin
        b_valid = 1'b0;
        b_seen  = b_t.size();
      end
      if (!b_valid && b_enable && b_issued < aw_q.size()) begin
        b_valid = 1'b1;
        b_resp  = (b_issued == bad_idx) ? 2'b10 : 2'b00;
        b_issued++;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic send_ctrl(input int plen, input logic [AW-1:0] addr,
                           input logic [UW-1:0] user, output bit ok);
    int n;
    bit got;
    n = 0; ok = 0;
    plen_tdata = 16'(plen); addr_tdata = addr; addr_tuser = user;
    plen_tvalid = 1'b1; addr_tvalid = 1'b1;
    forever begin
      #1 got = plen_tready && addr_tready;
      @(negedge clk);
      if (got) begin ok = 1; break; end
      n++;
      if (n > BUDGET) break;
    end
    plen_tvalid = 1'b0; addr_tvalid = 1'b0;
  endtask

  task automatic send_data(input int nb, input int tl, output bit ok);
    int n;
    bit got;
    ok = 1;
    for (int i = 0; i < nb && ok; i++) begin
      if (rand_ready && $urandom_range(0, 3) == 0) begin
        data_tvalid = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < DW / 32; k++) beat_data[i][k*32 +: 32] = $urandom;
      data_tdata = beat_data[i]; data_tlast = (i == tl); data_tvalid = 1'b1;
      n = 0;
      forever begin
        #1 got = data_tready;
        @(negedge clk);
        if (got) break;
        n++;
        if (n > BUDGET) begin ok = 0; break; end
      end
    end
    data_tvalid = 1'b0; data_tlast = 1'b0;
  endtask

  // One packet end to end: drive, predict from the packet rules, compare
  task automatic xfer_packet(input int plen, input logic [AW-1:0] addr, input logic [UW-1:0] user,
                             input int tlast_in, input bit bad_resp, input string tag);
    int nb, tl, awb, wb, n, r, exp_w;
    bit write, ok;
    logic [BPB-1:0] es;
    nb = (plen + BPB - 1) / BPB;
    write = (plen != 0) && (nb <= 256);
    tl = (tlast_in < 0) ? nb - 1 : tlast_in;
    awb = aw_q.size(); wb = w_q.size();
    if (bad_resp) bad_idx = awb;
    send_ctrl(plen, addr, user, ok);
    checks++;
    if (ok) passes++;
    else begin
      $display("FAIL %s ctrl_accept: got no handshake, required one within %0d cycles", tag, BUDGET);
      return;
    end
    if (!write) exp_err_plen = 1;
    if (write && tl != nb - 1) exp_err_tlast = 1;
    if (write) begin
      if (bad_resp) exp_err_bresp = 1;
      else exp_pw++;
    end
    if (plen != 0) begin
      send_data(nb, tl, ok);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s data_accept: got stalled stream, required %0d beats taken", tag, nb);
    end
    if (write) begin
      n = 0;
      while (aw_q.size() <= awb && n < BUDGET) begin @(negedge clk); n++; end
    end
    repeat (3) @(negedge clk);
    $display("pkt %s plen=%0d beats=%0d aw=%0d w=%0d", tag, plen, nb, aw_q.size() - awb, w_q.size() - wb);

    checks++;
    if (aw_q.size() - awb == (write ? 1 : 0)) passes++;
    else $display("FAIL %s aw_count: got %0d, required %0d", tag, aw_q.size() - awb, write ? 1 : 0);
    exp_w = write ? nb : 0;
    checks++;
    if (w_q.size() - wb == exp_w) passes++;
    else $display("FAIL %s w_count: got %0d, required %0d", tag, w_q.size() - wb, exp_w);

    if (write && aw_q.size() > awb) begin
      checks++;
      if (aw_q[awb].addr === addr && aw_q[awb].user === user) passes++;
      else $display("FAIL %s aw_addr_user: got %h/%h, required %h/%h", tag,
                    aw_q[awb].addr, aw_q[awb].user, addr, user);
      checks++;
      if (aw_q[awb].len === 8'(nb - 1)) passes++;
      else $display("FAIL %s aw_len: got %0d, required %0d", tag, aw_q[awb].len, nb - 1);
      checks++;
      if (aw_q[awb].size === 3'd6 && aw_q[awb].burst === 2'b01 && aw_q[awb].id === 4'd0) passes++;
      else $display("FAIL %s aw_size_burst_id: got %0d/%0d/%0d, required 6/1/0", tag,
                    aw_q[awb].size, aw_q[awb].burst, aw_q[awb].id);
    end

    if (write && w_q.size() - wb == nb) begin
      r = plen % BPB;
      for (int i = 0; i < nb; i++) begin
        es = '1;
        if (i == nb - 1 && r != 0) begin
          es = '0;
          for (int k = 0; k < r; k++) es[k] = 1'b1;
        end
        checks++;
        if (w_q[wb+i].data === beat_data[i] && w_q[wb+i].strb === es &&
            w_q[wb+i].last === (i == nb - 1)) passes++;
        else $display("FAIL %s beat%0d: got strb=%h last=%b data_ok=%b, required strb=%h last=%b data_ok=1",
                      tag, i, w_q[wb+i].strb, w_q[wb+i].last, w_q[wb+i].data === beat_data[i],
                      es, (i == nb - 1));
      end
    end

    if (b_enable) begin
      n = 0;
      #1;
      while (!(b_issued == aw_q.size() && !b_valid) && n < BUDGET) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      if (packets_written === 32'(exp_pw)) passes++;
      else $display("FAIL %s packets_written: got %0d, required %0d", tag, packets_written, exp_pw);
      checks++;
      if ({err_plen, err_tlast, err_bresp} === {exp_err_plen, exp_err_tlast, exp_err_bresp}) passes++;
      else $display("FAIL %s err_flags: got %b%b%b, required %b%b%b", tag, err_plen, err_tlast,
                    err_bresp, exp_err_plen, exp_err_tlast, exp_err_bresp);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    plen_tvalid = 1'b1; addr_tvalid = 1'b1; data_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({aw_valid, w_valid, b_ready, plen_tready, addr_tready, data_tready} === 6'b0) passes++;
    else $display("FAIL reset_handshakes: got %b, required 000000",
                  {aw_valid, w_valid, b_ready, plen_tready, addr_tready, data_tready});
    checks++;
    if ({err_plen, err_tlast, err_bresp} === 3'b0) passes++;
    else $display("FAIL reset_errs: got %b%b%b, required 000", err_plen, err_tlast, err_bresp);
    checks++;
    if (packets_written === 32'd0) passes++;
    else $display("FAIL reset_count: got %0d, required 0", packets_written);
    plen_tvalid = 1'b0; addr_tvalid = 1'b0; data_tvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (b_ready === 1'b1) passes++;
    else $display("FAIL bready_after_reset: got %b, required 1", b_ready);
    @(negedge clk);
    b_enable = 1;
  endtask

  task automatic test_single();
    xfer_packet(64, 64'h1000, 32'hA5, -1, 0, "single64");
  endtask

  task automatic test_partial();
    xfer_packet(130, 64'h8000, 32'h1234, -1, 0, "partial130");
  endtask

  task automatic test_oversize();
    xfer_packet(257 * BPB, 64'h4000, 32'h1, -1, 0, "oversize");
  endtask

  task automatic test_zero_plen();
    xfer_packet(0, 64'h5000, 32'h2, -1, 0, "zero_plen");
    xfer_packet(64, 64'h5040, 32'h3, -1, 0, "after_zero");
  endtask

  task automatic test_max_out();
    int base, bbase;
    base = aw_q.size(); bbase = b_t.size();
    b_enable = 0;
    xfer_packet(64, 64'h6000, 32'h10, -1, 0, "mo1");
    xfer_packet(128, 64'h6100, 32'h11, -1, 0, "mo2");
    fork
      xfer_packet(192, 64'h6200, 32'h12, -1, 0, "mo3");
      begin
        repeat (20) @(negedge clk);
        checks++;
        if (aw_q.size() - base == 2) passes++;
        else $display("FAIL max_out_hold: got %0d AWs, required 2", aw_q.size() - base);
        b_enable = 1;
      end
    join
    checks++;
    if (aw_q.size() > base + 2 && b_t.size() > bbase && aw_q[base+2].t > b_t[bbase]) passes++;
    else $display("FAIL max_out_order: third AW not after first B (aws=%0d bs=%0d)",
                  aw_q.size() - base, b_t.size() - bbase);
  endtask

  task automatic test_errors();
    xfer_packet(3 * BPB, 64'h7000, 32'h20, -1, 1, "bresp_err");
    xfer_packet(3 * BPB, 64'h7100, 32'h21, 1, 0, "early_tlast");
  endtask

  task automatic test_reset_mid();
    bit ok;
    b_enable = 0;
    send_ctrl(4 * BPB, 64'h9000, 32'h77, ok);
    checks++;
    if (ok) passes++;
    else $display("FAIL rm_ctrl: got no handshake, required one");
    send_data(1, 99, ok);
    checks++;
    if (ok) passes++;
    else $display("FAIL rm_beat1: got stalled stream, required beat taken");
    data_tdata = {16{32'hDEAD_BEEF}}; data_tlast = 1'b0; data_tvalid = 1'b1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({aw_valid, w_valid, b_ready, data_tready, plen_tready, addr_tready} === 6'b0) passes++;
    else $display("FAIL rm_outputs: got %b, required 000000",
                  {aw_valid, w_valid, b_ready, data_tready, plen_tready, addr_tready});
    @(negedge clk);
    checks++;
    if ({err_plen, err_tlast, err_bresp} === 3'b0 && packets_written === 32'd0) passes++;
    else $display("FAIL rm_regs: got errs=%b%b%b count=%0d, required 000/0",
                  err_plen, err_tlast, err_bresp, packets_written);
    resetn = 1'b1; data_tvalid = 1'b0;
    b_issued = aw_q.size(); b_seen = b_t.size();
    exp_err_plen = 0; exp_err_tlast = 0; exp_err_bresp = 0; exp_pw = 0;
    b_enable = 1;
    @(negedge clk);
    xfer_packet(300, 64'hA000, 32'h5A, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int i = 0; i < 12; i++)
      xfer_packet($urandom_range(1, 16 * BPB), {$urandom, $urandom}, $urandom, -1, 0, "rand");
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_oversize();
    test_zero_plen();
    test_max_out();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
